// File: rtl/udma_sdio_txn_sched.sv
// Two-requester round-robin transaction scheduler in front of the uDMA SDIO engine.
// Optional WAIT-state timeout is built in when UDMA_SDIO_SCHED_TIMEOUT_EN is defined.
module udma_sdio_txn_sched #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [11:0]          req_cmd_op_i,
  input  logic [63:0]          req_cmd_arg_i,
  input  logic [5:0]           req_rsp_type_i,
  input  logic [1:0]           req_data_en_i,
  output logic [5:0]           cfg_cmd_op_o,
  output logic [31:0]          cfg_cmd_arg_o,
  output logic [2:0]           cfg_cmd_rsp_type_o,
  output logic                 cfg_data_en_o,
  output logic                 cfg_sdio_start_o,
  input  logic                 eng_eot_i,
  input  logic                 eng_err_i,
  input  logic [TIMEOUT_W-1:0] timeout_cfg_i,
  output logic [1:0]           rsp_valid_o,
  output logic                 rsp_err_o,
  output logic                 rsp_timeout_o,
  output logic                 busy_o,
  output logic                 grant_id_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_prio;
  logic        w_grant;
  logic        w_winner;
  logic        w_done;
  logic        w_err_nxt;
  logic [1:0]  r_req_ready;
  logic [5:0]  r_cmd_op;
  logic [31:0] r_cmd_arg;
  logic [2:0]  r_rsp_type;
  logic        r_data_en;
  logic        r_start;
  logic [1:0]  r_rsp_valid;
  logic        r_rsp_err;
  logic        r_grant_id;

`ifdef UDMA_SDIO_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [TIMEOUT_W-1:0] w_cnt_inc;
  logic                 w_tmo_nxt;
  logic                 r_rsp_tmo;

  // The counter value after this WAIT cycle; a match means that many WAIT cycles have elapsed.
  assign w_cnt_inc = r_cnt + TIMEOUT_W'(1);
`else
  logic w_unused_tmo_cfg;
  assign w_unused_tmo_cfg = ^timeout_cfg_i;
`endif

  // Next-state, round-robin winner and completion status.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_winner    = r_prio;
    w_done      = 1'b0;
    w_err_nxt   = 1'b0;
`ifdef UDMA_SDIO_SCHED_TIMEOUT_EN
    w_tmo_nxt   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (|req_valid_i) begin
          w_grant     = 1'b1;
          w_winner    = req_valid_i[r_prio] ? r_prio : ~r_prio;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (eng_eot_i || eng_err_i) begin
          w_done      = 1'b1;
          w_err_nxt   = eng_err_i;
          w_state_nxt = S_RESP;
`ifdef UDMA_SDIO_SCHED_TIMEOUT_EN
        end else if ((timeout_cfg_i != '0) && (w_cnt_inc == timeout_cfg_i)) begin
          w_done      = 1'b1;
          w_err_nxt   = 1'b1;
          w_tmo_nxt   = 1'b1;
          w_state_nxt = S_RESP;
`endif
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, descriptor latch and single-cycle handshake pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_req_ready <= 2'b00;
      r_cmd_op    <= 6'd0;
      r_cmd_arg   <= 32'd0;
      r_rsp_type  <= 3'd0;
      r_data_en   <= 1'b0;
      r_start     <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rsp_err   <= 1'b0;
      r_grant_id  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= 2'b00;
      r_start     <= (r_state == S_START);
      r_rsp_valid <= 2'b00;
      if (w_grant) begin
        r_req_ready[w_winner] <= 1'b1;
        r_cmd_op    <= w_winner ? req_cmd_op_i[11:6]   : req_cmd_op_i[5:0];
        r_cmd_arg   <= w_winner ? req_cmd_arg_i[63:32] : req_cmd_arg_i[31:0];
        r_rsp_type  <= w_winner ? req_rsp_type_i[5:3]  : req_rsp_type_i[2:0];
        r_data_en   <= req_data_en_i[w_winner];
        r_grant_id  <= w_winner;
        r_prio      <= ~w_winner;
      end else begin
        r_grant_id  <= r_grant_id;
      end
      if (w_done) begin
        r_rsp_valid[r_grant_id] <= 1'b1;
        r_rsp_err               <= w_err_nxt;
      end else begin
        r_rsp_err <= r_rsp_err;
      end
    end
  end

`ifdef UDMA_SDIO_SCHED_TIMEOUT_EN
  // WAIT-cycle counter and latched timeout status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_rsp_tmo <= 1'b0;
    end else begin
      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= w_cnt_inc;
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_done) begin
        r_rsp_tmo <= w_tmo_nxt;
      end else begin
        r_rsp_tmo <= r_rsp_tmo;
      end
    end
  end

  assign rsp_timeout_o = r_rsp_tmo;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  assign req_ready_o        = r_req_ready;
  assign cfg_cmd_op_o       = r_cmd_op;
  assign cfg_cmd_arg_o      = r_cmd_arg;
  assign cfg_cmd_rsp_type_o = r_rsp_type;
  assign cfg_data_en_o      = r_data_en;
  assign cfg_sdio_start_o   = r_start;
  assign rsp_valid_o        = r_rsp_valid;
  assign rsp_err_o          = r_rsp_err;
  assign busy_o             = (r_state != S_IDLE);
  assign grant_id_o         = r_grant_id;

endmodule

// File: doc/udma_sdio_txn_sched.md
UDMA_SDIO_TXN_SCHED -- requirements
Module: udma_sdio_txn_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 16, meaning the width of the transaction timeout counter.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port req_valid_i, input, 2 bits: per-requester transaction request, where bit 0 is requester 0 and bit 1 is requester 1.
REQ-006 SHALL have port req_ready_o, output, 2 bits: one-cycle accept pulse to the granted requester.
REQ-007 SHALL have port req_cmd_op_i, input, 2x6 bits: per-requester SDIO command index.
REQ-008 SHALL have port req_cmd_arg_i, input, 2x32 bits: per-requester command argument.
REQ-009 SHALL have port req_rsp_type_i, input, 3 bits per requester (2x3): response type.
REQ-010 SHALL have port req_data_en_i, input, 2 bits: per-requester data-phase enable.
REQ-011 SHALL have port cfg_cmd_op_o, output, 6 bits; cfg_cmd_arg_o, output, 32 bits; cfg_cmd_rsp_type_o, output, 3 bits; cfg_data_en_o, output, 1 bit: latched descriptor driven to the SDIO engine.
REQ-012 SHALL have port cfg_sdio_start_o, output, 1 bit: engine start pulse.
REQ-013 SHALL have port eng_eot_i, input, 1 bit: engine end-of-transaction pulse.
REQ-014 SHALL have port eng_err_i, input, 1 bit: engine error pulse.
REQ-015 SHALL have port timeout_cfg_i, input, TIMEOUT_W bits: timeout limit in cycles, where 0 disables the timeout.
REQ-016 SHALL have port rsp_valid_o, output, 2 bits: one-cycle completion pulse to the owning requester.
REQ-017 SHALL have port rsp_err_o, output, 1 bit, and rsp_timeout_o, output, 1 bit: completion status, valid together with rsp_valid_o.
REQ-018 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.
REQ-019 SHALL have port grant_id_o, output, 1 bit: current or last owner.

Function
REQ-020 SHALL implement the FSM IDLE -> START -> WAIT -> RESP -> IDLE.
REQ-021 In IDLE with any req_valid_i set, SHALL grant round-robin: priority goes to the requester not granted last; after reset requester 0 has priority.
REQ-022 On grant, SHALL pulse req_ready_o[winner] for 1 cycle, latch the winner's descriptor into the cfg_* registers, set grant_id_o, and enter START.
REQ-023 In START, SHALL assert cfg_sdio_start_o for exactly 1 cycle, clear the timeout counter, and enter WAIT; the descriptor registers SHALL be stable from the START cycle until the next grant.
REQ-024 In WAIT, eng_eot_i or eng_err_i SHALL enter RESP; rsp_err_o is latched as eng_err_i, and simultaneous eot and err counts as an error.
REQ-025 In RESP, SHALL pulse rsp_valid_o[grant_id_o] for 1 cycle together with the latched rsp_err_o and rsp_timeout_o, then return to IDLE.
REQ-026 Earliest possible re-grant is the cycle after RESP; the minimum transaction is 4 cycles from the grant cycle.
REQ-027 Requests arriving while busy_o is high SHALL be held pending, not dropped; req_valid_i is level-sensitive.
REQ-028 eng_eot_i or eng_err_i outside WAIT SHALL be ignored.
REQ-029 A requester deasserting req_valid_i before the grant SHALL lose arbitration without side effects.

Reset
REQ-030 rst_i high at a clock edge SHALL force IDLE and set all outputs to 0, with round-robin priority to requester 0.
REQ-031 Reset mid-transaction SHALL abort the transaction with no rsp_valid_o pulse and no cfg_sdio_start_o pulse.

Configuration
REQ-032 With the macro UDMA_SDIO_SCHED_TIMEOUT_EN defined, the WAIT state SHALL increment a TIMEOUT_W-bit counter each cycle.
REQ-033 With UDMA_SDIO_SCHED_TIMEOUT_EN defined, when the counter equals a nonzero timeout_cfg_i with no eot/err in that cycle, SHALL enter RESP with rsp_timeout_o=1 and rsp_err_o=1; an eot in the same cycle as the match SHALL win.
REQ-034 Without UDMA_SDIO_SCHED_TIMEOUT_EN, no counter SHALL exist, rsp_timeout_o SHALL be tied to 0, and WAIT SHALL exit only on eot or err.

Verification
REQ-035 SHALL verify req_valid_i=01 with op=17, arg=0x0000_0200, then eot 5 cycles after start -> ready[0] pulse, start pulse 1 cycle later, rsp_valid_o=01, rsp_err_o=0.
REQ-036 SHALL verify req_valid_i=11 held for three transactions -> grants in order 0, 1, 0, with cfg_cmd_arg_o switching to the matching argument each time.
REQ-037 SHALL verify eng_err_i and eng_eot_i pulsed in the same WAIT cycle -> rsp_err_o=1, rsp_timeout_o=0.
REQ-038 SHALL verify, with UDMA_SDIO_SCHED_TIMEOUT_EN defined, timeout_cfg_i=8 and no eot -> RESP after 8 WAIT cycles with rsp_timeout_o=1; with timeout_cfg_i=0 and no eot -> the block stays in WAIT indefinitely.
REQ-039 SHALL verify rst_i asserted 2 cycles into WAIT -> busy_o=0 next cycle, no rsp_valid_o, and requester 0 wins the next 11 request.
REQ-040 SHALL verify eng_eot_i pulsed while IDLE -> no state change and no rsp_valid_o.
